// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Word geometry and the loader FSM encoding.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; first byte lands in [7:0].
// Zero latency: word_out already includes the byte being pushed this cycle.
// No backpressure of its own; the caller only pushes accepted bytes.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              full
);

  logic [WORD_W-1:0] buf_q;
  logic [WORD_W-1:0] buf_d;
  logic [1:0]        byte_cnt;

  always_comb begin
    buf_d = buf_q;
    if (push) begin
      buf_d[{byte_cnt, 3'b000} +: BYTE_W] = byte_in;
    end
  end

  // Exposing the merged value lets the owner register the word on the same
  // edge that accepts the last byte, without an extra cycle.
  assign word_out = buf_d;
  assign full     = push && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      buf_q    <= '0;
      byte_cnt <= '0;
    end else if (push) begin
      buf_q    <= buf_d;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte stream to instruction memory writer; holds the core in reset while loading.
// One write cycle after the 4th byte of each word; s_ready drops for that cycle.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [BYTE_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int               CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_WIDTH);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  word_cnt;
  logic              idle_or_done;
  logic              count_ok;
  logic              start_ok;
  logic              start_bad;
  logic              push;
  logic              full;
  logic              last_word;
  logic [WORD_W-1:0] pk_word;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign count_ok     = (word_count != '0) && (word_count <= MAX_WORDS);
  assign start_ok     = idle_or_done && start && count_ok;
  assign start_bad    = idle_or_done && start && !count_ok;
  assign push         = s_valid && s_ready;
  assign last_word    = (word_cnt + CNT_W'(1)) == count_q;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .push     (push),
    .byte_in  (s_data),
    .word_out (pk_word),
    .full     (full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_RECV;
      S_RECV:         if (full) state_nxt = S_WRITE;
      S_WRITE:        state_nxt = last_word ? S_DONE : S_RECV;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // word_cnt advances at the end of each write, so it names the next address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      count_q  <= word_count;
      word_cnt <= '0;
    end else if (state == S_WRITE) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= ~HOLD_AT_RESET;
    end else begin
      s_ready <= (state_nxt == S_RECV);
      imem_we <= (state_nxt == S_WRITE);
      busy    <= (state_nxt == S_RECV) || (state_nxt == S_WRITE);
      done    <= (state_nxt == S_DONE);

      if (start_ok) begin
        imem_addr <= '0;
      end else if (state_nxt == S_WRITE) begin
        imem_addr <= word_cnt[ADDR_WIDTH-1:0];
      end

      if (state_nxt == S_WRITE) begin
        imem_wdata <= pk_word;
      end

      if (start_ok) begin
        core_rst_n <= 1'b0;
      end else if (state_nxt == S_DONE) begin
        core_rst_n <= 1'b1;
      end

      if (start_ok) begin
        err <= 1'b0;
      end else if (start_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, errors, loads with and without gaps,
// reload from DONE, reset mid-load and a full MAX_WORDS image.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_n = 0;
  logic [AW-1:0] wr_addr [0:511];
  logic [31:0]   wr_data [0:511];
  int            wr_cyc  [0:511];
  logic [7:0]    tx_q [$];

  imem_loader #(.ADDR_WIDTH(AW), .HOLD_AT_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write log; the byte stream must be stalled during every write cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_n < 512) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
      check("we_sready_low", {31'd0, s_ready}, 32'd0);
    end
  end

  // Drives tx_q bytes; returns at the negedge after the last accepting edge.
  task automatic send(input bit gaps, input int stop_after);
    int acc;
    int guard;
    acc = 0;
    while (tx_q.size() > 0 && acc != stop_after) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = tx_q[0];
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        errors++;
        $error("FAIL send_timeout observed=s_ready_stuck_low expected=s_ready_high");
        s_valid = 1'b0;
        tx_q.delete();
        return;
      end
      @(negedge clk);
      void'(tx_q.pop_front());
      acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_start(input int wc);
    start      = 1'b1;
    word_count = (AW+1)'(wc);
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] b;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    @(negedge clk);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_core", {31'd0, core_rst_n}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Rejected starts
    do_start(0);
    check("err_zero", {31'd0, err}, 32'd1);
    check("err_zero_busy", {31'd0, busy}, 32'd0);
    do_start(257);
    check("err_257", {31'd0, err}, 32'd1);
    check("err_257_busy", {31'd0, busy}, 32'd0);
    check("err_257_sready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    check("err_no_write", wr_n, 32'd0);
    check("err_core", {31'd0, core_rst_n}, 32'd0);

    // Basic two-word load, no gaps
    wr_n = 0;
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    c0 = cyc;
    check("basic_err_clr", {31'd0, err}, 32'd0);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_sready", {31'd0, s_ready}, 32'd1);
    check("basic_core", {31'd0, core_rst_n}, 32'd0);
    send(1'b0, -1);
    @(negedge clk);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_core_rel", {31'd0, core_rst_n}, 32'd1);
    check("basic_busy_end", {31'd0, busy}, 32'd0);
    check("basic_nwr", wr_n, 32'd2);
    check("basic_a0", {24'd0, wr_addr[0]}, 32'd0);
    check("basic_d0", wr_data[0], 32'h00500013);
    check("basic_a1", {24'd0, wr_addr[1]}, 32'd1);
    check("basic_d1", wr_data[1], 32'h00100093);
    check("basic_lat", wr_cyc[0] - c0, 32'd4);
    check("basic_gap", wr_cyc[1] - wr_cyc[0], 32'd5);

    // Reload from DONE with gaps; a start during RECV is ignored
    wr_n = 0;
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_core", {31'd0, core_rst_n}, 32'd0);
    do_start(0);
    check("recv_start_no_err", {31'd0, err}, 32'd0);
    check("recv_start_busy", {31'd0, busy}, 32'd1);
    send(1'b1, -1);
    wait_done(50);
    check("bp_nwr", wr_n, 32'd2);
    check("bp_a0", {24'd0, wr_addr[0]}, 32'd0);
    check("bp_d0", wr_data[0], 32'h00500013);
    check("bp_a1", {24'd0, wr_addr[1]}, 32'd1);
    check("bp_d1", wr_data[1], 32'h00100093);

    // Start in DONE with one word
    wr_n = 0;
    do_start(1);
    check("done_start_core", {31'd0, core_rst_n}, 32'd0);
    check("done_start_done", {31'd0, done}, 32'd0);
    tx_q = '{8'h6F, 8'h00, 8'h00, 8'h00};
    send(1'b0, -1);
    wait_done(20);
    check("one_nwr", wr_n, 32'd1);
    check("one_a0", {24'd0, wr_addr[0]}, 32'd0);
    check("one_d0", wr_data[0], 32'h0000006F);

    // Reset after 5 accepted bytes
    wr_n = 0;
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    send(1'b0, 5);
    check("mid_nwr_before", wr_n, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_sready", {31'd0, s_ready}, 32'd0);
    check("mid_rst_core", {31'd0, core_rst_n}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAB;
    repeat (20) @(negedge clk);
    s_valid = 1'b0;
    tx_q.delete();
    check("mid_nwr_after", wr_n, 32'd1);
    check("mid_idle_busy", {31'd0, busy}, 32'd0);
    tx_q = '{8'h37, 8'h12, 8'h00, 8'h00};
    do_start(1);
    send(1'b0, -1);
    wait_done(20);
    check("mid_reload_nwr", wr_n, 32'd2);
    check("mid_reload_a", {24'd0, wr_addr[1]}, 32'd0);
    check("mid_reload_d", wr_data[1], 32'h00001237);

    // Full MAX_WORDS image
    wr_n = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      tx_q.push_back(b);
      tx_q.push_back(~b);
      tx_q.push_back(8'h5A);
      tx_q.push_back(b ^ 8'hA5);
    end
    do_start(256);
    send(1'b0, -1);
    wait_done(20);
    check("max_nwr", wr_n, 32'd256);
    check("max_a0", {24'd0, wr_addr[0]}, 32'd0);
    check("max_d0", wr_data[0], 32'hA55AFF00);
    check("max_a128", {24'd0, wr_addr[128]}, 32'd128);
    check("max_d128", wr_data[128], 32'h255A7F80);
    check("max_a255", {24'd0, wr_addr[255]}, 32'd255);
    check("max_d255", wr_data[255], 32'h5A5A00FF);
    check("max_core", {31'd0, core_rst_n}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
